mux_scan_ctrl: RTL and testbench

Round-robin scan controller that drives the 2-bit select of the 4:1 mux (mux4x1) and consumes its 1-bit output. For each channel it holds `sel` for DWELL cycles and samples the mux output on the last cycle. It then assembles the four samples into a 4-bit word and flags it with a one-cycle `valid` pulse. It replaces the free-running select counter with a start/continuous-controlled sequencer plus a capture register.

---
 rtl/mux_scan_ctrl_if.sv | 24 ++
 rtl/mux_scan_ctrl.sv | 107 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_if.sv
// Purpose : bundles the scan-controller request/mux/result signals into one port.
// Ports   : start/cont/mux_in are requests and mux data toward the controller;
//           sel/dout/valid/busy are the controller's registered results.
// Modports: master = the side that requests frames and closes the mux path,
//           slave  = the controller itself.
interface mux_scan_ctrl_if;
    logic       start;   // level request to begin a frame, honoured only when idle
    logic       cont;    // continuous mode, looked at only on the frame-end edge
    logic       mux_in;  // mux output, combinational from sel
    logic [1:0] sel;     // mux select
    logic [3:0] dout;    // last completed frame, dout[i] sampled while sel==i
    logic       valid;   // one-cycle pulse: dout updated this cycle
    logic       busy;    // frame in progress

    modport master (
        output start, cont, mux_in,
        input  sel, dout, valid, busy
    );

    modport slave (
        input  start, cont, mux_in,
        output sel, dout, valid, busy
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Purpose     : round-robin scan of a 4:1 mux; holds sel DWELL cycles per channel,
//               samples mux_in on the last cycle, publishes the 4-bit frame.
// Latency     : valid rises the cycle after edge E0+4*DWELL (E0 = accepting edge).
// Backpressure: none; start is ignored while busy (not queued).
// Ports       : clk, rst (synchronous, active-high), bus (mux_scan_ctrl_if.slave).
//               All outputs come straight from registers.
module mux_scan_ctrl #(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux_scan_ctrl_if.slave   bus
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q,   sel_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    // Samples of channels 0..2; channel 3 goes straight into dout at frame end.
    logic [2:0]      shift_q, shift_d;
    logic [3:0]      dout_q,  dout_d;
    logic            valid_q, valid_d;
    logic            busy_q,  busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            cnt_q   <= '0;
            shift_q <= 3'b000;
            dout_q  <= 4'b0000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                sel_d = 2'b00;
                cnt_d = '0;
                if (bus.start) begin
                    state_d = SCAN;
                    busy_d  = 1'b1;
                end
            end

            SCAN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    // Dwell boundary: sel has been stable DWELL cycles, take the sample.
                    cnt_d = '0;
                    if (sel_q != 2'd3) begin
                        shift_d[sel_q] = bus.mux_in;
                        sel_d          = sel_q + 2'd1;
                    end else begin
                        dout_d  = {bus.mux_in, shift_q};
                        valid_d = 1'b1;
                        sel_d   = 2'b00;
                        // cont matters only here, so mid-frame changes are harmless.
                        if (!bus.cont) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = 2'b00;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.sel   = sel_q;
    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with DWELL=4, one with DWELL=1,
// each behind its own interface and a behavioural 4:1 mux (mux_in = din[sel]).
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] din4;
    logic [3:0] din1;

    int n_cmp;
    int n_err;

    mux_scan_ctrl_if bus4();
    mux_scan_ctrl_if bus1();

    assign bus4.mux_in = din4[bus4.sel];
    assign bus1.mux_in = din1[bus1.sel];

    mux_scan_ctrl #(.DWELL(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    mux_scan_ctrl #(.DWELL(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus4.start = 1'b1;
        bus1.start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({bus4.sel, bus4.dout, bus4.valid, bus4.busy} !== 8'h00) begin
                n_err++;
                $display("FAIL reset_dw4 cyc%0d: sel=%b dout=%b valid=%b busy=%b, want all 0",
                         i, bus4.sel, bus4.dout, bus4.valid, bus4.busy);
            end
            n_cmp++;
            if ({bus1.sel, bus1.dout, bus1.valid, bus1.busy} !== 8'h00) begin
                n_err++;
                $display("FAIL reset_dw1 cyc%0d: sel=%b dout=%b valid=%b busy=%b, want all 0",
                         i, bus1.sel, bus1.dout, bus1.valid, bus1.busy);
            end
        end
        rst = 1'b0;
        bus4.start = 1'b0;
        bus1.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bus4.busy, bus4.valid, bus4.sel, bus1.busy, bus1.valid} !== 7'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc%0d: busy4=%b valid4=%b sel4=%b busy1=%b valid1=%b, want 0",
                         i, bus4.busy, bus4.valid, bus4.sel, bus1.busy, bus1.valid);
            end
        end
    endtask

    task automatic test_oneshot;
        logic [1:0] exp_sel;
        din4 = 4'b1010;
        bus4.cont = 1'b0;
        bus4.start = 1'b1;
        tick();                     // E0
        bus4.start = 1'b0;
        n_cmp++;
        if (bus4.busy !== 1'b1 || bus4.sel !== 2'b00) begin
            n_err++;
            $display("FAIL oneshot_start: busy=%b sel=%b, want busy=1 sel=00", bus4.busy, bus4.sel);
        end
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp_sel = (k < 16) ? 2'(k / 4) : 2'b00;
            n_cmp++;
            if (bus4.sel !== exp_sel || bus4.valid !== (k == 16) || bus4.busy !== (k < 16)) begin
                n_err++;
                $display("FAIL oneshot k=%0d: sel=%b valid=%b busy=%b, want sel=%b valid=%b busy=%b",
                         k, bus4.sel, bus4.valid, bus4.busy, exp_sel, (k == 16), (k < 16));
            end
            if (k >= 16) begin
                n_cmp++;
                if (bus4.dout !== 4'b1010) begin
                    n_err++;
                    $display("FAIL oneshot_dout k=%0d: dout=%b, want 1010", k, bus4.dout);
                end
            end
        end
    endtask

    task automatic test_continuous;
        logic [3:0] exp_dout;
        din1 = 4'b0011;
        bus1.cont = 1'b1;
        bus1.start = 1'b1;
        tick();                     // E0
        bus1.start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_cmp++;
            if (bus1.valid !== (k % 4 == 0 && k <= 16) || bus1.busy !== (k < 16)) begin
                n_err++;
                $display("FAIL cont k=%0d: valid=%b busy=%b, want valid=%b busy=%b",
                         k, bus1.valid, bus1.busy, (k % 4 == 0 && k <= 16), (k < 16));
            end
            if (k % 4 == 0 && k <= 16) begin
                // Frame 2 straddles the change: ch0/ch1 old data, ch2/ch3 new.
                exp_dout = (k == 4) ? 4'b0011 : (k == 8) ? 4'b1111 : 4'b1100;
                n_cmp++;
                if (bus1.dout !== exp_dout) begin
                    n_err++;
                    $display("FAIL cont_dout k=%0d: dout=%b, want %b", k, bus1.dout, exp_dout);
                end
            end
            if (k == 6) din1 = 4'b1100;
            if (k == 12) bus1.cont = 1'b0;
        end
    endtask

    task automatic test_start_busy;
        logic [1:0] exp_sel;
        din4 = 4'b0110;
        bus4.cont = 1'b0;
        bus4.start = 1'b1;
        tick();                     // E0
        bus4.start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp_sel = (k < 16) ? 2'(k / 4) : 2'b00;
            n_cmp++;
            if (bus4.sel !== exp_sel || bus4.valid !== (k == 16) || bus4.busy !== (k < 16)) begin
                n_err++;
                $display("FAIL start_busy k=%0d: sel=%b valid=%b busy=%b, want sel=%b valid=%b busy=%b",
                         k, bus4.sel, bus4.valid, bus4.busy, exp_sel, (k == 16), (k < 16));
            end
            if (k == 16) begin
                n_cmp++;
                if (bus4.dout !== 4'b0110) begin
                    n_err++;
                    $display("FAIL start_busy_dout: dout=%b, want 0110", bus4.dout);
                end
            end
            bus4.start = (k == 3 || k == 9 || k == 14);
        end
        bus4.start = 1'b0;
    endtask

    task automatic test_back_to_back;
        din4 = 4'b1001;
        bus4.cont = 1'b0;
        bus4.start = 1'b1;
        tick();                     // E0; start stays high
        for (int k = 1; k <= 36; k++) begin
            tick();
            n_cmp++;
            if (bus4.valid !== (k == 16 || k == 33) || bus4.busy !== (k != 16 && k < 33)) begin
                n_err++;
                $display("FAIL b2b k=%0d: valid=%b busy=%b, want valid=%b busy=%b",
                         k, bus4.valid, bus4.busy, (k == 16 || k == 33), (k != 16 && k < 33));
            end
            if (k == 17 || k == 33) begin
                n_cmp++;
                if (bus4.sel !== 2'b00 || bus4.dout !== 4'b1001) begin
                    n_err++;
                    $display("FAIL b2b_sel_dout k=%0d: sel=%b dout=%b, want sel=00 dout=1001",
                             k, bus4.sel, bus4.dout);
                end
            end
            if (k == 33) bus4.start = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        din4 = 4'b1111;
        bus4.cont = 1'b0;
        bus4.start = 1'b1;
        tick();                     // E0
        bus4.start = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        n_cmp++;
        if (bus4.sel !== 2'b10 || bus4.busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_pre: sel=%b busy=%b, want sel=10 busy=1", bus4.sel, bus4.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({bus4.sel, bus4.busy, bus4.dout, bus4.valid} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid: sel=%b busy=%b dout=%b valid=%b, want all 0",
                     bus4.sel, bus4.busy, bus4.dout, bus4.valid);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (bus4.valid !== 1'b0 || bus4.busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_quiet k=%0d: valid=%b busy=%b, want 0", k, bus4.valid, bus4.busy);
            end
        end
        din4 = 4'b0101;
        bus4.start = 1'b1;
        tick();                     // E0
        bus4.start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            n_cmp++;
            if (bus4.valid !== (k == 16)) begin
                n_err++;
                $display("FAIL reset_mid_refr k=%0d: valid=%b, want %b", k, bus4.valid, (k == 16));
            end
            if (k == 16) begin
                n_cmp++;
                if (bus4.dout !== 4'b0101) begin
                    n_err++;
                    $display("FAIL reset_mid_refr_dout: dout=%b, want 0101", bus4.dout);
                end
            end
        end
    endtask

    task automatic test_cont_drop;
        din4 = 4'b1100;
        bus4.cont = 1'b1;
        bus4.start = 1'b1;
        tick();                     // E0
        bus4.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_cmp++;
            if (bus4.valid !== (k == 16) || bus4.busy !== (k < 16)) begin
                n_err++;
                $display("FAIL cont_drop k=%0d: valid=%b busy=%b, want valid=%b busy=%b",
                         k, bus4.valid, bus4.busy, (k == 16), (k < 16));
            end
            if (k == 16) begin
                n_cmp++;
                if (bus4.dout !== 4'b1100) begin
                    n_err++;
                    $display("FAIL cont_drop_dout: dout=%b, want 1100", bus4.dout);
                end
            end
            if (k == 5) bus4.cont = 1'b0;   // channel 1 dwell
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        din4 = 4'b0000;
        din1 = 4'b0000;
        bus4.start = 1'b0;
        bus4.cont = 1'b0;
        bus1.start = 1'b0;
        bus1.cont = 1'b0;
        #2;
        test_reset();
        test_oneshot();
        test_continuous();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_cont_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
